// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control, setting and display signals of the egg-timer main counter.
// master: driver side (control FSM, setting counters, display).
// slave: the timer itself.
// Signals:
//   sec_pulse, enable, load       - strobe/enable/load from prescaler and control FSM
//   set_min_tens .. set_sec_ones  - BCD MM:SS value to load
//   min_tens .. sec_ones          - current BCD MM:SS count
//   timer_done, done_pulse, beep  - expiry level, expiry strobe, alarm drive
interface countdown_timer_if;
    logic       sec_pulse;
    logic       enable;
    logic       load;
    logic [3:0] set_min_tens;
    logic [3:0] set_min_ones;
    logic [3:0] set_sec_tens;
    logic [3:0] set_sec_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;
    logic       done_pulse;
    logic       beep;
    modport master (
        output sec_pulse, enable, load, set_min_tens, set_min_ones, set_sec_tens, set_sec_ones,
        input  min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, beep
    );
    modport slave (
        input  sec_pulse, enable, load, set_min_tens, set_min_ones, set_sec_tens, set_sec_ones,
        output min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, beep
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS cooking-time counter, decremented once per second.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - countdown_timer_if.slave (load/enable/sec_pulse in, digits/done/beep out)
// Optional: define ALARM_BEEP_EN to build the post-expiry beep counter; otherwise beep is 0.
module countdown_timer #(
    parameter int MAX_MIN_TENS = 9,
    parameter int BEEP_SECONDS = 5
) (
    input logic clk,
    input logic reset,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {ZERO, ARMED, COUNTING} state_t;
    localparam logic [3:0] MT = 4'(MAX_MIN_TENS);
    if (MAX_MIN_TENS > 9 || BEEP_SECONDS < 1) begin : g_bad_param
        $error("countdown_timer: MAX_MIN_TENS must be <= 9 and BEEP_SECONDS >= 1");
    end
    state_t state, state_nx;
    logic [3:0] mt, mo, st, so;
    logic [3:0] l_mt, l_mo, l_st, l_so;
    logic [3:0] d_mt, d_mo, d_st, d_so;
    logic [3:0] mt_nx, mo_nx, st_nx, so_nx;
    logic min_clamp, sec_clamp, zero, dec, l_zero, d_zero, dp, dp_nx;
    always_comb begin
        sec_clamp = bus.set_sec_tens > 4'd5 || bus.set_sec_ones > 4'd9;
        min_clamp = bus.set_min_tens > MT || bus.set_min_ones > 4'd9;
        l_mt = min_clamp ? MT : bus.set_min_tens;
        l_mo = min_clamp ? 4'd9 : bus.set_min_ones;
        l_st = sec_clamp ? 4'd5 : bus.set_sec_tens;
        l_so = sec_clamp ? 4'd9 : bus.set_sec_ones;
        l_zero = {l_mt, l_mo, l_st, l_so} == 16'd0;
        zero = {mt, mo, st, so} == 16'd0;
        dec = bus.enable && bus.sec_pulse && !zero;
        // Chained borrow: each digit wraps only when every lower digit is 0.
        d_so = so == 4'd0 ? 4'd9 : so - 4'd1;
        d_st = so != 4'd0 ? st : st == 4'd0 ? 4'd5 : st - 4'd1;
        d_mo = {st, so} != 8'd0 ? mo : mo == 4'd0 ? 4'd9 : mo - 4'd1;
        d_mt = {mo, st, so} != 12'd0 ? mt : mt - 4'd1;
        d_zero = {d_mt, d_mo, d_st, d_so} == 16'd0;
        mt_nx = bus.load ? l_mt : dec ? d_mt : mt;
        mo_nx = bus.load ? l_mo : dec ? d_mo : mo;
        st_nx = bus.load ? l_st : dec ? d_st : st;
        so_nx = bus.load ? l_so : dec ? d_so : so;
        dp_nx = !bus.load && dec && d_zero;
        state_nx = bus.load ? (l_zero ? ZERO : ARMED) :
                   dec ? (d_zero ? ZERO : COUNTING) :
                   state == ZERO ? ZERO :
                   bus.enable ? COUNTING : ARMED;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ZERO;
            {mt, mo, st, so} <= 16'd0;
            dp <= 1'b0;
        end else begin
            state <= state_nx;
            {mt, mo, st, so} <= {mt_nx, mo_nx, st_nx, so_nx};
            dp <= dp_nx;
        end
    end
    assign bus.min_tens = mt;
    assign bus.min_ones = mo;
    assign bus.sec_tens = st;
    assign bus.sec_ones = so;
    assign bus.timer_done = zero;
    assign bus.done_pulse = dp;
`ifdef ALARM_BEEP_EN
    localparam int BW = $clog2(BEEP_SECONDS + 1);
    logic [BW-1:0] beep_cnt;
    logic beep_q;
    // Counts remaining sec_pulse events after expiry; beep toggles on each.
    always_ff @(posedge clk) begin
        if (reset || bus.load) begin
            beep_cnt <= '0;
            beep_q <= 1'b0;
        end else if (dp) begin
            beep_cnt <= BW'(BEEP_SECONDS);
            beep_q <= 1'b0;
        end else if (beep_cnt == '0) begin
            beep_q <= 1'b0;
        end else if (bus.sec_pulse) begin
            beep_cnt <= beep_cnt - 1'b1;
            beep_q <= ~beep_q;
        end
    end
    assign bus.beep = beep_q;
`else
    assign bus.beep = 1'b0;
`endif
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and randomized check of countdown_timer against a seconds-based model.
module tb_countdown_timer;
    localparam int MAXT = 9;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    int m_min = 0;
    int m_sec = 0;
    bit exp_dp = 1'b0;
    countdown_timer_if bus ();
    countdown_timer #(.MAX_MIN_TENS(MAXT), .BEEP_SECONDS(5)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] digits();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction
    function automatic logic [15:0] model_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction
    // Model keeps minutes/seconds as integers and decrements total seconds.
    task automatic cycle();
        int total;
        @(posedge clk);
        exp_dp = 1'b0;
        if (reset) begin
            m_min = 0;
            m_sec = 0;
        end else if (bus.load) begin
            m_min = (int'(bus.set_min_tens) > MAXT || bus.set_min_ones > 4'd9) ? MAXT * 10 + 9
                    : int'(bus.set_min_tens) * 10 + int'(bus.set_min_ones);
            m_sec = (bus.set_sec_tens > 4'd5 || bus.set_sec_ones > 4'd9) ? 59
                    : int'(bus.set_sec_tens) * 10 + int'(bus.set_sec_ones);
        end else if (bus.enable && bus.sec_pulse && (m_min * 60 + m_sec) > 0) begin
            total = m_min * 60 + m_sec - 1;
            m_min = total / 60;
            m_sec = total % 60;
            exp_dp = total == 0;
        end
        #1;
        check("digits", 32'(digits()), 32'(model_digits()));
        check("timer_done", 32'(bus.timer_done), 32'(m_min == 0 && m_sec == 0));
        check("done_pulse", 32'(bus.done_pulse), 32'(exp_dp));
`ifndef ALARM_BEEP_EN
        check("beep", 32'(bus.beep), 32'd0);
`endif
    endtask
    task automatic drive(input bit r, input bit l, input bit e, input bit p, input logic [15:0] v);
        reset = r;
        bus.load = l;
        bus.enable = e;
        bus.sec_pulse = p;
        {bus.set_min_tens, bus.set_min_ones, bus.set_sec_tens, bus.set_sec_ones} = v;
        cycle();
    endtask
    initial begin
        logic [15:0] v;
        reset = 1'b1;
        bus.load = 1'b0;
        bus.enable = 1'b0;
        bus.sec_pulse = 1'b0;
        {bus.set_min_tens, bus.set_min_ones, bus.set_sec_tens, bus.set_sec_ones} = 16'h0;
        drive(1, 0, 0, 0, 16'h0);
        check("reset_digits", 32'(digits()), 32'h0);
        check("reset_done", 32'(bus.timer_done), 32'd1);
        check("reset_pulse", 32'(bus.done_pulse), 32'd0);
        drive(0, 1, 1, 0, 16'h0100);
        check("load_0100_done", 32'(bus.timer_done), 32'd0);
        repeat (3) begin
            drive(0, 0, 1, 1, 16'h0);
            drive(0, 0, 1, 0, 16'h0);
        end
        check("dec3_0057", 32'(digits()), 32'h0057);
        drive(0, 1, 1, 0, 16'h0002);
        drive(0, 0, 1, 1, 16'h0);
        check("dec_0001", 32'(digits()), 32'h0001);
        drive(0, 0, 1, 1, 16'h0);
        check("expire_digits", 32'(digits()), 32'h0);
        check("expire_done", 32'(bus.timer_done), 32'd1);
        check("expire_pulse", 32'(bus.done_pulse), 32'd1);
        drive(0, 0, 1, 1, 16'h0);
        check("no_wrap", 32'(digits()), 32'h0);
        check("pulse_one_cycle", 32'(bus.done_pulse), 32'd0);
        drive(0, 1, 1, 0, 16'h1000);
        drive(0, 0, 1, 1, 16'h0);
        check("borrow_0959", 32'(digits()), 32'h0959);
        v = {4'd0, 4'd12, 4'd7, 4'd0};
        drive(0, 1, 0, 0, v);
        check("clamp_9959", 32'(digits()), 32'h9959);
        v = {4'd11, 4'd3, 4'd2, 4'd14};
        drive(0, 1, 0, 0, v);
        check("clamp_9959_b", 32'(digits()), 32'h9959);
        drive(0, 1, 1, 0, 16'h0);
        check("load_zero_done", 32'(bus.timer_done), 32'd1);
        check("load_zero_pulse", 32'(bus.done_pulse), 32'd0);
        drive(0, 1, 1, 0, 16'h0030);
        drive(0, 1, 1, 1, 16'h0500);
        check("load_wins_tick", 32'(digits()), 32'h0500);
        repeat (4) drive(0, 0, 0, 1, 16'h0);
        check("hold_disabled", 32'(digits()), 32'h0500);
        drive(0, 0, 1, 1, 16'h0);
        check("resume_0459", 32'(digits()), 32'h0459);
        drive(1, 0, 1, 1, 16'h0);
        check("reset_mid_digits", 32'(digits()), 32'h0);
        check("reset_mid_pulse", 32'(bus.done_pulse), 32'd0);
        for (int i = 0; i < 3000; i++) begin
            v = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                 4'($urandom_range(0, 2) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 1)),
                 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 11))};
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, v);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Main cooking-time counter directly downstream of the egg-timer control FSM.
- Takes the load strobe and count enable from the control FSM, plus the BCD minutes:seconds value from the setting counters.
- Decrements once per one-second pulse and returns timer_done to the control FSM.
- Drives the MM:SS BCD digits to the display mux.

Parameters:
- MAX_MIN_TENS, 9: highest legal minutes-tens digit; loaded values above it clamp the minutes field to MAX_MIN_TENS:9.
- BEEP_SECONDS, 5: number of seconds the optional alarm output stays active after expiry.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sec_pulse  input  1  one-cycle strobe, once per second, from the prescaler
- enable  input  1  count enable (main_timer_enable from control FSM)
- load  input  1  load strobe (load_timer from control FSM)
- set_min_tens  input  4  BCD minutes tens from setting counters
- set_min_ones  input  4  BCD minutes ones
- set_sec_tens  input  4  BCD seconds tens
- set_sec_ones  input  4  BCD seconds ones
- min_tens  output  4  current BCD minutes tens
- min_ones  output  4  current BCD minutes ones
- sec_tens  output  4  current BCD seconds tens
- sec_ones  output  4  current BCD seconds ones
- timer_done  output  1  level; high while count == 00:00
- done_pulse  output  1  one-cycle strobe on the expiry transition
- beep  output  1  alarm drive (only with ALARM_BEEP_EN; otherwise tied 0)

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - All digits 0; timer_done = 1 (count is zero); done_pulse = 0; beep = 0; state = ZERO.
- State machine (registered):
  - ZERO: count == 00:00.
  - ARMED: count != 0, not decrementing.
  - COUNTING: count != 0, enable high.
- Transitions:
  - ZERO -> ARMED on load of a nonzero value. Loading 00:00 stays in ZERO.
  - ARMED <-> COUNTING follows enable.
  - COUNTING -> ZERO when a decrement reaches 00:00.
  - Any state -> ARMED or ZERO on load, according to the loaded value.
- Priority per cycle: reset > load > decrement.
  - load and sec_pulse in the same cycle: the loaded value is taken; that tick is dropped.
- Load:
  - Sampled on posedge clk; the new digits are visible the next cycle (1-cycle latency).
  - Clamping, applied independently per field:
    - Seconds field: a tens digit >5 or a ones digit >9 clamps the field to 59.
    - Minutes field: a tens digit >MAX_MIN_TENS or a ones digit >9 clamps the field to MAX_MIN_TENS:9.
- Decrement:
  - Occurs when enable and sec_pulse are both high and count != 0.
  - Chained BCD borrow: sec_ones 0 -> 9 borrows into sec_tens; sec_tens 0 -> 5 borrows into min_ones; min_ones 0 -> 9 borrows into min_tens.
  - The counter never wraps below 00:00. In ZERO, sec_pulse is ignored even when enable is high.
- timer_done: decoded from the digit registers, so it is valid in the same cycle the digits update.
- done_pulse: high for exactly one cycle, the cycle after the decrement that produced 00:00.
  - Never asserted by a load of 00:00 or by reset.
- enable low mid-count: digits hold; a later enable resumes from the held value.
- Reset mid-count: digits go to 0 on the next edge; done_pulse is not asserted.

Optional Feature:
- Macro: ALARM_BEEP_EN.
- Defined:
  - done_pulse starts a beep seconds counter.
  - beep toggles every clk cycle in which sec_pulse is high, for BEEP_SECONDS sec_pulse events, then returns to 0.
  - A load or reset cancels the beep immediately, with beep = 0 the next cycle.
  - A new done_pulse restarts the count.
- Undefined: no beep counter logic is built and beep is tied to 0.

Test Plan:
- Reset, then load 01:00 with enable=1 and 3 sec_pulses -> digits 00:57; timer_done=0 after the load; state COUNTING.
- Load 00:02, enable=1, 2 sec_pulses -> 00:01, then 00:00; timer_done rises with the 00:00 digits; done_pulse high exactly one cycle; further pulses keep 00:00.
- Load 10:00, one sec_pulse -> 09:59; verifies the chained borrow across all four digits.
- Load with set_sec_tens=7, set_min_ones=12 -> the seconds field reads 59, the minutes field reads MAX_MIN_TENS:9; load with all digits 0 -> timer_done stays 1, no done_pulse.
- Running at 00:30, assert load(05:00) and sec_pulse in the same cycle -> 05:00 next cycle (tick dropped). Then enable=0 plus 4 pulses -> holds at 05:00. Then reset mid-count -> 00:00, done_pulse=0.
- With ALARM_BEEP_EN, expire from 00:01 -> beep toggles on each of 5 following sec_pulses, then 0; a repeat run with load mid-beep -> beep=0 the next cycle.
